// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first, with a registered borrow.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to 0 when the final borrow is set.
module serial_subtractor #(
  parameter  int WIDTH = 3,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bor;

  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_res_nxt;
  logic [WIDTH-1:0]   w_diff_fin;

  // Single full-subtractor cell on the current LSBs.
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // The minuend register doubles as the result register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  assign w_res_nxt = {w_d, r_a[WIDTH-1:1]};

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_SAT_EN
  assign w_diff_fin = w_br_nxt ? '0 : w_res_nxt;
`else
  assign w_diff_fin = w_res_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bor  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= w_res_nxt;
      r_b   <= r_b >> 1;
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      // diff/borrow_out only change on entry to DONE and hold until the next one.
      if (w_last) begin
        r_diff <= w_diff_fin;
        r_bor  <= w_br_nxt;
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_bor;

endmodule
